regfile_client: RTL and testbench
=================================

# regfile_client

Command-driven initiator for the 32x32 register file's read/write port. It accepts one command at a time over a valid/ready handshake and sequences the file's read-enable, address, write-enable and reset lines. It returns read data, or a completion acknowledge, over a second valid/ready handshake. It sits between a datapath controller or debug/load port and the register file, and is the only block that drives the file's ports.

## Interface
- RD_LAT, 1, cycles from driving read addresses with rf_read_enable high to the cycle in which rf_out_data_* is sampled (legal 1..4)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when both cmd_valid and cmd_ready are high
- cmd_op  in  2  00 read pair, 01 write, 10 fill range, 11 clear all
- cmd_addr_a  in  5  read port-1 address, write address, or fill start address
- cmd_addr_b  in  5  read port-2 address
- cmd_data  in  32  write/fill data
- cmd_count  in  5  fill length; 0 means 32
- rf_read_enable  out  1  to register file read_enable
- rf_out_addr_1  out  5  to register file out_addr_1
- rf_out_addr_2  out  5  to register file out_addr_2
- rf_out_data_1  in  32  from register file out_data_1
- rf_out_data_2  in  32  from register file out_data_2
- rf_write_enable  out  1  to register file write_enable
- rf_in_addr  out  5  to register file in_addr
- rf_in_data  out  32  to register file in_data
- rf_reset  out  1  to register file reset (synchronous clear on clk)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high
- rsp_data_1  out  32  port-1 read data; 0 for non-read ops
- rsp_data_2  out  32  port-2 read data; 0 for non-read ops

## Operation
- FSM states:
  - IDLE: cmd_ready=1.
  - READ: drive addresses, rf_read_enable=1, down-counter of RD_LAT cycles.
  - WRITE: one cycle, rf_write_enable=1.
  - FILL: one write per cycle.
  - CLEAR: one cycle, rf_reset=1.
  - RESP: hold rsp_valid until rsp_ready.
- Transitions:
  - IDLE to READ, WRITE, FILL or CLEAR on handshake, selected by cmd_op.
  - READ, WRITE and CLEAR go to RESP when done. FILL goes to RESP after its last write.
  - RESP goes to IDLE on rsp handshake.
- All command fields are latched on acceptance. Changes to cmd_* after acceptance have no effect.
- Exactly one response is produced per accepted command. No new command is accepted until that response is consumed.
- Read: rf_out_addr_1/2 = latched addr_a/addr_b throughout READ. rf_out_data_1/2 are captured into rsp_data_1/2 at the rising edge that ends the last READ cycle. The captured values stay stable through RESP regardless of register-file activity.
- Write: rf_in_addr=addr_a and rf_in_data=data for one cycle. The file updates at the edge ending that cycle.
- Fill: writes data to addresses addr_a, addr_a+1, … for N writes, where N = count, or 32 if count=0. The address is 5-bit and wraps 31 to 0. With N=32 every register is written exactly once.
- Clear all: rf_reset is high for exactly one cycle, then the response is issued.
- rf_write_enable, rf_reset and rf_read_enable are never high in the same cycle.
- Outside their active states, all rf_* outputs are 0.
- Reset (asynchronous, any state): the FSM goes to IDLE and all outputs go to 0, including cmd_ready. Any in-flight command is dropped with no response. A partially completed fill leaves already-written registers modified. cmd_ready=1 in the first cycle after reset deasserts.

## Timing
- Command accepted at edge E0, meaning the cycle-0 handshake completes at that edge.
- Read:
  - READ spans cycles 1..RD_LAT.
  - rsp_valid rises in cycle RD_LAT+1.
  - With RD_LAT=1, the read-to-response latency is 2 cycles.
- Write: the WRITE cycle is cycle 1; the register updates at the end of cycle 1; rsp_valid is high in cycle 2.
- Fill of N: writes occur in cycles 1..N; rsp_valid is high in cycle N+1.
- Clear: rf_reset is high in cycle 1; rsp_valid is high in cycle 2.
- RESP with rsp_ready already high lasts one cycle, and cmd_ready is high the following cycle. A back-to-back read therefore costs RD_LAT+2 cycles per command.
- rsp_valid, once high, stays high with stable data until the handshake.

## Test plan
- Reset then idle: assert reset mid-cycle -> all outputs 0 asynchronously; after release cmd_ready=1 and rsp_valid=0.
- Write then read: write addr 5 = 0xDEADBEEF, then read pair (5, 0) -> rsp_data_1=0xDEADBEEF and rsp_data_2=0; rsp_valid exactly 2 cycles after the read is accepted (RD_LAT=1).
- Fill with wrap: fill start 30, count 4, data 0xA5A5A5A5 -> writes to 30, 31, 0, 1 in consecutive cycles; reading 29 and 2 returns their prior values.
- Fill count 0 then clear: fill 32 writes of 0x1 -> all registers read 1; then clear all -> rf_reset high for one cycle and every register reads 0.
- Response backpressure: read with rsp_ready low for 5 cycles while cmd_valid stays high -> cmd_ready stays 0, rsp_data stays stable, exactly one response.
- Reset mid-fill: assert reset during the 3rd write of a count-8 fill -> no response; only the first 2 or 3 addresses are modified, and the next command is handled normally.

Source files
------------

// File: rtl/regfile_client.sv
// Command-driven initiator for the 32x32 register file: sequences read, write,
// fill and clear-all operations and returns one response per accepted command.
module regfile_client #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_addr_a,
  input  logic [4:0]  cmd_addr_b,
  input  logic [31:0] cmd_data,
  input  logic [4:0]  cmd_count,
  output logic        rf_read_enable,
  output logic [4:0]  rf_out_addr_1,
  output logic [4:0]  rf_out_addr_2,
  input  logic [31:0] rf_out_data_1,
  input  logic [31:0] rf_out_data_2,
  output logic        rf_write_enable,
  output logic [4:0]  rf_in_addr,
  output logic [31:0] rf_in_data,
  output logic        rf_reset,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data_1,
  output logic [31:0] rsp_data_2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FILL,
    S_CLEAR,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  addr_a_q, addr_a_d;
  logic [4:0]  addr_b_q, addr_b_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rsp1_q, rsp1_d;
  logic [31:0] rsp2_q, rsp2_d;
  logic [5:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_q   <= '0;
      rsp1_q   <= '0;
      rsp2_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      data_q   <= data_d;
      rsp1_q   <= rsp1_d;
      rsp2_q   <= rsp2_d;
      cnt_q    <= cnt_d;
    end
  end

  // addr_a_q doubles as the running fill address; cnt_q is the read latency
  // countdown or the number of fill writes still to issue.
  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    data_d   = data_q;
    rsp1_d   = rsp1_q;
    rsp2_d   = rsp2_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_a_d = cmd_addr_a;
          addr_b_d = cmd_addr_b;
          data_d   = cmd_data;
          rsp1_d   = '0;
          rsp2_d   = '0;
          unique case (cmd_op)
            2'b00: begin
              state_d = S_READ;
              cnt_d   = 6'(RD_LAT - 1);
            end
            2'b01: state_d = S_WRITE;
            2'b10: begin
              state_d = S_FILL;
              cnt_d   = (cmd_count == 5'd0) ? 6'd32 : {1'b0, cmd_count};
            end
            default: state_d = S_CLEAR;
          endcase
        end
      end
      S_READ: begin
        if (cnt_q == 6'd0) begin
          rsp1_d  = rf_out_data_1;
          rsp2_d  = rf_out_data_2;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_FILL: begin
        addr_a_d = addr_a_q + 5'd1;
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_RESP;
      end
      S_CLEAR: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready       = (state_q == S_IDLE) && !reset;
    rsp_valid       = (state_q == S_RESP);
    rsp_data_1      = rsp_valid ? rsp1_q : '0;
    rsp_data_2      = rsp_valid ? rsp2_q : '0;
    rf_read_enable  = 1'b0;
    rf_out_addr_1   = '0;
    rf_out_addr_2   = '0;
    rf_write_enable = 1'b0;
    rf_in_addr      = '0;
    rf_in_data      = '0;
    rf_reset        = 1'b0;
    unique case (state_q)
      S_READ: begin
        rf_read_enable = 1'b1;
        rf_out_addr_1  = addr_a_q;
        rf_out_addr_2  = addr_b_q;
      end
      S_WRITE, S_FILL: begin
        rf_write_enable = 1'b1;
        rf_in_addr      = addr_a_q;
        rf_in_data      = data_q;
      end
      S_CLEAR: rf_reset = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_client.sv
// Bench for regfile_client: emulated register file, cycle-timeline model of the
// expected command behaviour, per-cycle comparison and directed scenarios.
module tb_regfile_client;
  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_addr_a = '0;
  logic [4:0]  cmd_addr_b = '0;
  logic [31:0] cmd_data = '0;
  logic [4:0]  cmd_count = '0;
  logic        rf_read_enable;
  logic [4:0]  rf_out_addr_1, rf_out_addr_2;
  logic [31:0] rf_out_data_1, rf_out_data_2;
  logic        rf_write_enable;
  logic [4:0]  rf_in_addr;
  logic [31:0] rf_in_data;
  logic        rf_reset;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data_1, rsp_data_2;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int rst_cnt = 0;

  regfile_client #(.RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
    .cmd_count(cmd_count),
    .rf_read_enable(rf_read_enable), .rf_out_addr_1(rf_out_addr_1),
    .rf_out_addr_2(rf_out_addr_2), .rf_out_data_1(rf_out_data_1),
    .rf_out_data_2(rf_out_data_2), .rf_write_enable(rf_write_enable),
    .rf_in_addr(rf_in_addr), .rf_in_data(rf_in_data), .rf_reset(rf_reset),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_1(rsp_data_1), .rsp_data_2(rsp_data_2)
  );

  always #5 clk = ~clk;

  // Emulated register file: synchronous clear and write, combinational read.
  logic [31:0] rf_mem [32] = '{default: '0};
  always @(posedge clk) begin
    if (rf_reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_write_enable) begin
      rf_mem[rf_in_addr] <= rf_in_data;
    end
  end
  assign rf_out_data_1 = rf_mem[rf_out_addr_1];
  assign rf_out_data_2 = rf_mem[rf_out_addr_2];

  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) rsp_cnt++;
    if (rf_reset) rst_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected register contents plus the current command and the index
  // of the cycle (1-based, counted from acceptance) now in progress.
  logic [31:0] m_mem [32] = '{default: '0};
  bit          m_busy = 1'b0;
  logic [1:0]  m_op;
  logic [4:0]  m_a, m_b;
  logic [31:0] m_d, m_r1, m_r2;
  int unsigned m_n, m_k;

  function automatic int unsigned rsp_cycle(input logic [1:0] op, input int unsigned n);
    if (op == 2'd0) return LAT + 1;
    if (op == 2'd2) return n + 1;
    return 2;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1'b1;
        m_op = cmd_op; m_a = cmd_addr_a; m_b = cmd_addr_b; m_d = cmd_data;
        m_n = (cmd_count == 5'd0) ? 32 : int'(cmd_count);
        m_r1 = '0; m_r2 = '0;
        m_k = 1;
      end
    end else if (m_k >= rsp_cycle(m_op, m_n)) begin
      if (rsp_ready) m_busy = 1'b0;
    end else begin
      case (m_op)
        2'd0: if (m_k == LAT) begin m_r1 = m_mem[m_a]; m_r2 = m_mem[m_b]; end
        2'd1: m_mem[m_a] = m_d;
        2'd2: m_mem[m_a + 5'(m_k - 1)] = m_d;
        default: for (int i = 0; i < 32; i++) m_mem[i] = '0;
      endcase
      m_k++;
    end
  end

  bit          e_rsp, e_re, e_we, e_rst;
  logic [4:0]  e_waddr;
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_data_1", rsp_data_1, 0);
      chk("rst_rsp_data_2", rsp_data_2, 0);
      chk("rst_rf_ctl", {rf_read_enable, rf_write_enable, rf_reset}, 0);
      chk("rst_rf_addr", {rf_out_addr_1, rf_out_addr_2, rf_in_addr}, 0);
      chk("rst_rf_in_data", rf_in_data, 0);
    end else begin
      e_rsp   = m_busy && m_k >= rsp_cycle(m_op, m_n);
      e_re    = m_busy && m_op == 2'd0 && m_k <= LAT;
      e_we    = m_busy && ((m_op == 2'd1 && m_k == 1) || (m_op == 2'd2 && m_k <= m_n));
      e_rst   = m_busy && m_op == 2'd3 && m_k == 1;
      e_waddr = (m_op == 2'd1) ? m_a : m_a + 5'(m_k - 1);
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("rsp_data_1", rsp_data_1, (e_rsp && m_op == 2'd0) ? m_r1 : 0);
      chk("rsp_data_2", rsp_data_2, (e_rsp && m_op == 2'd0) ? m_r2 : 0);
      chk("rf_read_enable", 32'(rf_read_enable), 32'(e_re));
      chk("rf_out_addr_1", 32'(rf_out_addr_1), e_re ? 32'(m_a) : 0);
      chk("rf_out_addr_2", 32'(rf_out_addr_2), e_re ? 32'(m_b) : 0);
      chk("rf_write_enable", 32'(rf_write_enable), 32'(e_we));
      chk("rf_in_addr", 32'(rf_in_addr), e_we ? 32'(e_waddr) : 0);
      chk("rf_in_data", rf_in_data, e_we ? m_d : 0);
      chk("rf_reset", 32'(rf_reset), 32'(e_rst));
    end
  end

  task automatic wait_accept(input string tag);
    bit ok = 1'b0;
    for (int g = 0; g < 50 && !ok; g++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) chk({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] d, input logic [4:0] cnt);
    cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d; cmd_count = cnt;
    cmd_valid = 1'b1;
    wait_accept("send");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr_a = 5'($urandom); cmd_addr_b = 5'($urandom);
    cmd_data = $urandom; cmd_count = 5'($urandom);
  endtask

  task automatic wait_rsp(output logic [31:0] r1, output logic [31:0] r2, output int lat);
    bit got = 1'b0;
    lat = 0; r1 = 'x; r2 = 'x;
    for (int g = 0; g < 100 && !got; g++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin got = 1'b1; r1 = rsp_data_1; r2 = rsp_data_2; end
    end
    if (!got) chk("rsp_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] d, input logic [4:0] cnt,
                        output logic [31:0] r1, output logic [31:0] r2, output int lat);
    send(op, a, b, d, cnt);
    wait_rsp(r1, r2, lat);
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b,
                    input logic [31:0] e1, input logic [31:0] e2, input string tag);
    logic [31:0] r1, r2;
    int lat;
    do_cmd(2'd0, a, b, 32'h0, 5'd0, r1, r2, lat);
    chk({tag, "_d1"}, r1, e1);
    chk({tag, "_d2"}, r2, e2);
    chk({tag, "_lat"}, lat, 2);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] r1, r2;
    int lat;
    do_cmd(2'd1, a, 5'd0, d, 5'd0, r1, r2, lat);
    chk("wr_lat", lat, 2);
    chk("wr_rsp", r1 | r2, 0);
  endtask

  initial begin
    logic [31:0] r1, r2;
    int lat, base;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;

    // Write then read
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd0, 32'hDEADBEEF, 32'h0, "wr_rd");

    // Response backpressure with the next command already waiting
    rsp_ready = 1'b0;
    cmd_op = 2'd0; cmd_addr_a = 5'd5; cmd_addr_b = 5'd0; cmd_valid = 1'b1;
    wait_accept("bp");
    @(posedge clk); #1;
    cmd_addr_a = 5'd29; cmd_addr_b = 5'd2;
    begin
      bit got = 1'b0;
      for (int g = 0; g < 50 && !got; g++) begin
        @(negedge clk);
        got = rsp_valid;
      end
      if (!got) chk("bp_rsp_timeout", 0, 1);
    end
    base = rsp_cnt;
    repeat (5) begin
      chk("bp_cmd_ready", 32'(cmd_ready), 0);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_d1", rsp_data_1, 32'hDEADBEEF);
      chk("bp_d2", rsp_data_2, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_one_rsp", rsp_cnt, base + 1);
    wait_accept("bp2");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(r1, r2, lat);
    chk("bp2_d", r1 | r2, 0);
    chk("bp2_rsp", rsp_cnt, base + 2);

    // Fill with address wrap
    wr(5'd29, 32'h29292929);
    wr(5'd2, 32'h22222222);
    do_cmd(2'd2, 5'd30, 5'd0, 32'hA5A5A5A5, 5'd4, r1, r2, lat);
    chk("fill4_lat", lat, 5);
    chk("fill4_rsp", r1 | r2, 0);
    chk("model_mem31", m_mem[31], 32'hA5A5A5A5);
    rd(5'd29, 5'd2, 32'h29292929, 32'h22222222, "fill_edges");
    rd(5'd30, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, "fill_hi");
    rd(5'd0, 5'd1, 32'hA5A5A5A5, 32'hA5A5A5A5, "fill_wrap");

    // Fill all 32, then clear all
    do_cmd(2'd2, 5'd7, 5'd0, 32'h1, 5'd0, r1, r2, lat);
    chk("fill32_lat", lat, 33);
    for (int i = 0; i < 16; i++) rd(5'(i), 5'(i + 16), 32'h1, 32'h1, "fill32");
    base = rst_cnt;
    do_cmd(2'd3, 5'd0, 5'd0, 32'h0, 5'd0, r1, r2, lat);
    chk("clr_lat", lat, 2);
    chk("clr_pulses", rst_cnt, base + 1);
    for (int i = 0; i < 16; i++) rd(5'(i), 5'(i + 16), 32'h0, 32'h0, "clr");

    // Reset during the third write of a count-8 fill
    send(2'd2, 5'd10, 5'd0, 32'h77, 5'd8);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_we", 32'(rf_write_enable), 0);
    chk("midrst_ready", 32'(cmd_ready), 0);
    chk("midrst_in_addr", 32'(rf_in_addr), 0);
    base = rsp_cnt;
    @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    chk("midrst_post_ready", 32'(cmd_ready), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_rsp", rsp_cnt, base);
    rd(5'd10, 5'd11, 32'h77, 32'h77, "midrst_done");
    rd(5'd12, 5'd13, 32'h0, 32'h0, "midrst_untouched");
    wr(5'd17, 32'h12345678);
    rd(5'd17, 5'd9, 32'h12345678, 32'h0, "after_midrst");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
